ip_host_seq: RTL and testbench

Host-side job sequencer for a processing-core slot. It streams a job's input words into the core's input memory, writes the configuration register, and pulses `start`. It then waits for the core's `done_f`, reads the core's output memory back, and streams the results out. It sits between a word-stream source/sink (DMA or CPU bridge) and the core's memory and control ports, and drives the same `start`/`confReg`/`done_f` interface that the core controller answers.

---
 rtl/ip_host_seq.sv | 158 +++++++++++++++
 tb/tb_ip_host_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_host_seq.sv
// Host-side job sequencer: streams a job into the core's input memory, kicks the core,
// waits for done_f under a watchdog, then drains the core's output memory as a stream.
module ip_host_seq #(
  parameter int unsigned ADDR_WIDTH_MEMI = 6,
  parameter int unsigned ADDR_WIDTH_MEMO = 6,
  parameter int unsigned SIZE_CR         = 1,
  parameter int unsigned TIMEOUT_CYC     = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_a,
  input  logic                       en_s,
  input  logic                       go,
  input  logic [SIZE_CR*32-1:0]      cfg_word,
  input  logic [31:0]                src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic [ADDR_WIDTH_MEMI-1:0] memi_addr,
  output logic [31:0]                memi_data,
  output logic                       memi_we,
  output logic [SIZE_CR*32-1:0]      confReg,
  output logic                       start,
  input  logic                       done_f,
  output logic [ADDR_WIDTH_MEMO-1:0] memo_addr,
  input  logic [31:0]                memo_data,
  output logic [31:0]                dst_data,
  output logic                       dst_valid,
  input  logic                       dst_ready,
  output logic                       host_busy,
  output logic                       job_done,
  output logic                       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_DONE,
    S_DRAIN_RD,
    S_DRAIN_OUT,
    S_FIN
  } state_e;

  localparam bit          WDOG_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYC - 1);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH_MEMI-1:0] memi_addr_q, memi_addr_d;
  logic [ADDR_WIDTH_MEMO-1:0] memo_addr_q, memo_addr_d;
  logic [SIZE_CR*32-1:0]      conf_q, conf_d;
  logic [31:0]                dst_data_q, dst_data_d;
  logic                       dst_valid_q, dst_valid_d;
  logic                       timeout_err_q, timeout_err_d;
  logic [31:0]                wdog_q, wdog_d;

  // NOTE: every register gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    memi_addr_d   = memi_addr_q;
    memo_addr_d   = memo_addr_q;
    conf_d        = conf_q;
    dst_data_d    = dst_data_q;
    dst_valid_d   = dst_valid_q;
    timeout_err_d = timeout_err_q;
    wdog_d        = wdog_q;
    src_ready     = 1'b0;
    memi_we       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d       = S_LOAD;
          conf_d        = cfg_word;
          timeout_err_d = 1'b0;
          memi_addr_d   = '0;
          memo_addr_d   = '0;
        end
      end
      S_LOAD: begin
        // A stalled cycle must neither accept a word nor write the memory.
        src_ready = en_s;
        if (src_valid && en_s) begin
          memi_we     = 1'b1;
          memi_addr_d = memi_addr_q + ADDR_WIDTH_MEMI'(1);
          if (&memi_addr_q) state_d = S_KICK;
        end
      end
      S_KICK: begin
        wdog_d  = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_f) begin
          state_d = S_DRAIN_RD;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      S_DRAIN_RD: begin
        dst_data_d  = memo_data;
        dst_valid_d = 1'b1;
        state_d     = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (dst_ready) begin
          dst_valid_d = 1'b0;
          memo_addr_d = memo_addr_q + ADDR_WIDTH_MEMO'(1);
          state_d     = (&memo_addr_q) ? S_FIN : S_DRAIN_RD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q       <= S_IDLE;
      memi_addr_q   <= '0;
      memo_addr_q   <= '0;
      conf_q        <= '0;
      dst_data_q    <= '0;
      dst_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else if (en_s) begin
      state_q       <= state_d;
      memi_addr_q   <= memi_addr_d;
      memo_addr_q   <= memo_addr_d;
      conf_q        <= conf_d;
      dst_data_q    <= dst_data_d;
      dst_valid_q   <= dst_valid_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

  // start/job_done decode straight from state, so a stall stretches them naturally.
  assign start       = (state_q == S_KICK);
  assign job_done    = (state_q == S_FIN);
  assign host_busy   = (state_q != S_IDLE);
  assign memi_addr   = memi_addr_q;
  assign memi_data   = memi_we ? src_data : 32'd0;
  assign memo_addr   = memo_addr_q;
  assign confReg     = conf_q;
  assign dst_data    = dst_data_q;
  assign dst_valid   = dst_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ip_host_seq.sv
// Bench for ip_host_seq: randomized jobs compared against a transaction-level model of
// the expected memory writes, drained words and event cycle numbers.
module tb_ip_host_seq;
  localparam int AW = 2;
  localparam int NW = 1 << AW;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_a;
  logic          en_s;
  logic          go;
  logic [31:0]   cfg_word;
  logic [31:0]   src_data;
  logic          src_valid;
  logic          src_ready;
  logic [AW-1:0] memi_addr;
  logic [31:0]   memi_data;
  logic          memi_we;
  logic [31:0]   confReg;
  logic          start;
  logic          done_f;
  logic [AW-1:0] memo_addr;
  logic [31:0]   memo_data;
  logic [31:0]   dst_data;
  logic          dst_valid;
  logic          dst_ready;
  logic          host_busy;
  logic          job_done;
  logic          timeout_err;

  ip_host_seq #(
    .ADDR_WIDTH_MEMI(AW),
    .ADDR_WIDTH_MEMO(AW),
    .SIZE_CR        (1),
    .TIMEOUT_CYC    (TO)
  ) dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .en_s       (en_s),
    .go         (go),
    .cfg_word   (cfg_word),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .memi_addr  (memi_addr),
    .memi_data  (memi_data),
    .memi_we    (memi_we),
    .confReg    (confReg),
    .start      (start),
    .done_f     (done_f),
    .memo_addr  (memo_addr),
    .memo_data  (memo_data),
    .dst_data   (dst_data),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .host_busy  (host_busy),
    .job_done   (job_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core output memory: address presented in a cycle, data sampled at its closing edge.
  logic [31:0] out_mem [NW];
  assign memo_data = out_mem[memo_addr];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int failures = 0;

  // Event log gathered mid-cycle on the falling edge.
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  logic [31:0]   out_q     [$];
  int start_cnt, jd_cnt, jd_cyc, first_dv, dv_cnt, last_acc, to_cyc, stall_cyc, hold_viol;
  bit start_p, dv_p, jd_p, to_p, held_p;
  logic [31:0] held_data;

  always @(negedge clk) begin
    if (rst_a) begin
      start_p = 1'b0; dv_p = 1'b0; jd_p = 1'b0; to_p = 1'b0; held_p = 1'b0;
    end else begin
      if (memi_we) begin
        wr_addr_q.push_back(memi_addr);
        wr_data_q.push_back(memi_data);
      end
      if (start && !start_p) start_cnt++;
      if (dst_valid && !dv_p && first_dv < 0) first_dv = cyc_n;
      if (dst_valid) dv_cnt++;
      if (dst_valid && dst_ready && en_s) begin
        out_q.push_back(dst_data);
        last_acc = cyc_n;
      end
      if (held_p && (!dst_valid || dst_data !== held_data)) hold_viol++;
      if (dst_valid && !dst_ready) stall_cyc++;
      held_p    = dst_valid && !dst_ready;
      held_data = dst_data;
      if (job_done && !jd_p) begin
        jd_cnt++;
        jd_cyc = cyc_n;
      end
      if (timeout_err && !to_p) to_cyc = cyc_n;
      start_p = start; dv_p = dst_valid; jd_p = job_done; to_p = timeout_err;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
    start_cnt = 0; jd_cnt = 0; jd_cyc = -1; first_dv = -1; dv_cnt = 0;
    last_acc = -1; to_cyc = -1; stall_cyc = 0; hold_viol = 0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".src_ready"}, src_ready, 0);
    check({nm, ".memi_addr"}, memi_addr, 0);
    check({nm, ".memi_data"}, memi_data, 0);
    check({nm, ".memi_we"}, memi_we, 0);
    check({nm, ".confReg"}, confReg, 0);
    check({nm, ".start"}, start, 0);
    check({nm, ".memo_addr"}, memo_addr, 0);
    check({nm, ".dst_data"}, dst_data, 0);
    check({nm, ".dst_valid"}, dst_valid, 0);
    check({nm, ".host_busy"}, host_busy, 0);
    check({nm, ".job_done"}, job_done, 0);
    check({nm, ".timeout_err"}, timeout_err, 0);
  endtask

  // One complete job. done_dly: cycles from the (effective) start cycle to done_f, <0 = never.
  task automatic run_job(input string nm, input logic [31:0] cfg, input bit fixed_words,
                         input bit bubbles, input int done_dly, input int stall_word,
                         input bit go_noise, input int kick_stall);
    logic [31:0] in_w [NW];
    int t1, s, s_eff, d, idx, budget, stall_left;
    bit acc, en_tested, exp_to;
    for (int i = 0; i < NW; i++) begin
      in_w[i]    = fixed_words ? 32'h10 + 32'(i) : $urandom;
      out_mem[i] = $urandom;
    end
    clear_logs();
    exp_to = (done_dly < 0) || (done_dly > TO);

    cfg_word = cfg; go = 1'b1;
    tick();
    go = 1'b0;
    t1 = cyc_n;
    check({nm, ".busy_rise"}, host_busy, 1);
    check({nm, ".src_ready_rise"}, src_ready, 1);
    check({nm, ".to_cleared"}, timeout_err, 0);
    check({nm, ".conf_capture"}, confReg, cfg);

    idx = 0; budget = 0; en_tested = 1'b0;
    while (idx < NW && budget < 200) begin
      budget++;
      if (bubbles && idx == 2 && !en_tested) begin
        en_tested = 1'b1; en_s = 1'b0; src_valid = 1'b1; src_data = in_w[idx];
        #1;
        check({nm, ".stall_src_ready"}, src_ready, 0);
        check({nm, ".stall_memi_we"}, memi_we, 0);
        tick();
        en_s = 1'b1;
      end else begin
        src_data  = in_w[idx];
        src_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        if (go_noise && idx == 1) begin
          go = 1'b1; cfg_word = ~cfg;
        end
        #1;
        acc = src_valid && src_ready;
        tick();
        go = 1'b0; cfg_word = cfg;
        if (acc) idx++;
      end
    end
    src_valid = 1'b0;
    check({nm, ".load_words"}, idx, NW);

    budget = 0;
    while (!start && budget < 20) begin
      tick();
      budget++;
    end
    check({nm, ".start_seen"}, start, 1);
    s = cyc_n;
    if (!bubbles) check({nm, ".start_cycle"}, s, t1 + NW);
    if (kick_stall > 0) begin
      en_s = 1'b0;
      for (int i = 0; i < kick_stall; i++) begin
        tick();
        check({nm, ".start_stretch"}, start, 1);
      end
      en_s = 1'b1;
    end
    s_eff = s + kick_stall;

    d = -1;
    if (done_dly >= 0) begin
      while (cyc_n < s_eff + done_dly) begin
        go = (go_noise && cyc_n == s_eff + 1);
        tick();
      end
      go = 1'b0;
      done_f = 1'b1;
      d = cyc_n;
      tick();
      done_f = 1'b0;
    end

    stall_left = 3; budget = 0;
    while (jd_cnt == 0 && budget < 400) begin
      budget++;
      if (stall_word >= 0 && out_q.size() == stall_word && dst_valid && stall_left > 0) begin
        dst_ready = 1'b0;
        stall_left--;
      end else begin
        dst_ready = 1'b1;
      end
      tick();
    end
    dst_ready = 1'b1;
    check({nm, ".job_done_events"}, jd_cnt, 1);
    check({nm, ".job_done_pulse"}, job_done, 0);
    check({nm, ".busy_fall"}, host_busy, 0);

    check({nm, ".memi_writes"}, wr_addr_q.size(), NW);
    for (int i = 0; i < NW && i < wr_addr_q.size(); i++) begin
      check({nm, ".memi_addr"}, wr_addr_q[i], i);
      check({nm, ".memi_data"}, wr_data_q[i], in_w[i]);
    end
    check({nm, ".start_events"}, start_cnt, 1);
    check({nm, ".conf_final"}, confReg, cfg);
    check({nm, ".timeout_err"}, timeout_err, exp_to);
    if (exp_to) begin
      check({nm, ".timeout_cycle"}, to_cyc, s_eff + 1 + TO);
      check({nm, ".no_dst_valid"}, dv_cnt, 0);
      check({nm, ".job_done_cycle"}, jd_cyc, s_eff + 1 + TO);
    end else begin
      check({nm, ".out_words"}, out_q.size(), NW);
      for (int i = 0; i < NW && i < out_q.size(); i++)
        check({nm, ".out_data"}, out_q[i], out_mem[i]);
      check({nm, ".first_dst_valid"}, first_dv, d + 2);
      check({nm, ".job_done_cycle"}, jd_cyc, last_acc + 1);
      check({nm, ".dst_hold"}, hold_viol, 0);
      if (stall_word >= 0) check({nm, ".stall_cycles"}, stall_cyc, 3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_a = 1'b1; en_s = 1'b1; go = 1'b1; cfg_word = $urandom;
    src_data = $urandom; src_valid = 1'b1; done_f = 1'b0; dst_ready = 1'b1;
    for (int i = 0; i < NW; i++) out_mem[i] = $urandom;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    go = 1'b0; src_valid = 1'b0;
    rst_a = 1'b0;
    tick();
    check("idle.busy", host_busy, 0);

    run_job("basic",  32'h5,     1'b1, 1'b0, 5,                     -1, 1'b0, 0);
    run_job("bubble", $urandom,  1'b0, 1'b1, $urandom_range(1, 15),  2, 1'b0, 0);
    run_job("wdog",   $urandom,  1'b0, 1'b0, -1,                    -1, 1'b0, 0);
    run_job("edge",   $urandom,  1'b0, 1'b0, TO,                    -1, 1'b0, 0);
    run_job("noise",  $urandom,  1'b0, 1'b0, $urandom_range(3, 12), -1, 1'b1, 0);

    // Abort a job while it sits in DRAIN_OUT under backpressure.
    clear_logs();
    for (int i = 0; i < NW; i++) out_mem[i] = $urandom | 32'h1;
    cfg_word = $urandom | 32'h1; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 40 && !start; i++) begin
      src_valid = 1'b1; src_data = $urandom;
      tick();
    end
    src_valid = 1'b0; dst_ready = 1'b0;
    repeat (3) tick();
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    for (int i = 0; i < 10 && !dst_valid; i++) tick();
    check("abort.in_drain", dst_valid, 1);
    tick();
    #2;
    rst_a = 1'b1;
    #1;
    check_zero("abort");
    check("abort.no_job_done", jd_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; dst_ready = 1'b1;

    run_job("kick", $urandom, 1'b0, 1'b0, $urandom_range(1, 10), -1, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
